// File: rtl/control_filtro.sv
// Sequencer for the 3x3 Gaussian filter: fetches nine taps over a req/ack port,
// accumulates them with kernel 1 2 1 / 2 4 2 / 1 2 1, and offers sum>>4 on valid/ready.
module control_filtro #(
   parameter int ADDR_W = 12,
   parameter int PIX_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_in,
   input  logic [7:0]        ancho,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              res_valid,
   output logic [PIX_W-1:0]  res_data,
   input  logic              res_ready,
   output logic              busy,
   output logic [3:0]        idx,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, FETCH, OUT} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] row_q;
   logic [7:0]        stride_q;
   logic [PIX_W+3:0]  acc_q;
   logic [3:0]        idx_q;
   logic [PIX_W-1:0]  res_q;
   logic              err_q;

   logic [PIX_W+3:0]  pix_ext;
   logic [PIX_W+3:0]  tap_w;
   logic [PIX_W+3:0]  acc_d;
   logic [ADDR_W-1:0] row_d;

   // Kernel weight by tap number: centre x4, edge-adjacent (even taps) x2, corners x1.
   always_comb begin
      pix_ext = {4'b0000, mem_rdata};
      tap_w   = pix_ext;
      if (idx_q == 4'd5) begin
         tap_w = pix_ext << 2;
      end else if (!idx_q[0]) begin
         tap_w = pix_ext << 1;
      end
      acc_d = acc_q + tap_w;
      row_d = row_q + ADDR_W'(stride_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         row_q    <= '0;
         stride_q <= '0;
         acc_q    <= '0;
         idx_q    <= 4'd1;
         res_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (ancho < 8'd3) begin
                     err_q <= 1'b1;
                  end else begin
                     addr_q   <= base_in;
                     row_q    <= base_in;
                     stride_q <= ancho;
                     acc_q    <= '0;
                     idx_q    <= 4'd1;
                     state_q  <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  acc_q <= acc_d;
                  if (idx_q == 4'd9) begin
                     res_q   <= acc_d[PIX_W+3:4];
                     state_q <= OUT;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                     // Column wrap after taps 3 and 6 jumps to the next row base.
                     if (idx_q == 4'd3 || idx_q == 4'd6) begin
                        addr_q <= row_d;
                        row_q  <= row_d;
                     end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                     end
                  end
               end
            end
            OUT: begin
               if (res_ready) begin
                  idx_q   <= 4'd1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req   = (state_q == FETCH);
   assign res_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign mem_addr  = addr_q;
   assign res_data  = res_q;
   assign idx       = idx_q;
   assign err       = err_q;

endmodule

// File: tb/tb_control_filtro.sv
// Directed and randomized windows for control_filtro, checked against a
// reference that computes addresses and the weighted sum straight from the kernel.
module tb_control_filtro;

   localparam int ADDR_W = 12;
   localparam int PIX_W  = 8;
   localparam int MEM_N  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_in;
   logic [7:0]        ancho;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [PIX_W-1:0]  mem_rdata;
   logic              res_valid;
   logic [PIX_W-1:0]  res_data;
   logic              res_ready;
   logic              busy;
   logic [3:0]        idx;
   logic              err;

   logic [PIX_W-1:0] mem_img [MEM_N];
   int kern [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
   int total = 0;
   int bad   = 0;

   control_filtro #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_in   (base_in),
      .ancho     (ancho),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .busy      (busy),
      .idx       (idx),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] tap_addr(input int base, input int stride, input int k);
      return ADDR_W'(base + ((k - 1) / 3) * stride + (k - 1) % 3);
   endfunction

   function automatic int ref_result(input int base, input int stride);
      int sum = 0;
      for (int k = 1; k <= 9; k++) sum += kern[k-1] * int'(mem_img[tap_addr(base, stride, k)]);
      return sum / 16;
   endfunction

   task automatic fill(input int val);
      for (int i = 0; i < MEM_N; i++) mem_img[i] = PIX_W'(val);
   endtask

   task automatic fill_random();
      for (int i = 0; i < MEM_N; i++) mem_img[i] = PIX_W'($urandom_range(0, 255));
   endtask

   // One full window: wait_n stall cycles before each ack, res_ready low for
   // hold_n cycles of OUT, optional stray start (ancho=2) during a stall.
   task automatic run_window(input int base, input int stride, input int wait_n,
                             input int hold_n, input bit mid_start);
      int exp;
      exp = ref_result(base, stride);
      @(negedge clk);
      start     = 1'b1;
      base_in   = ADDR_W'(base);
      ancho     = 8'(stride);
      res_ready = (hold_n == 0);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 1; k <= 9; k++) begin
         for (int w = 0; w < wait_n; w++) begin
            chk($sformatf("wait_addr_t%0d", k), mem_addr, tap_addr(base, stride, k));
            chk($sformatf("wait_idx_t%0d", k), idx, k);
            chk($sformatf("wait_req_t%0d", k), mem_req, 1);
            if (mid_start && k == 4 && w == 0) begin
               start   = 1'b1;
               ancho   = 8'd2;
               base_in = '0;
            end
            @(negedge clk);
            start = 1'b0;
            if (mid_start && k == 4 && w == 0) chk("no_err_when_busy", err, 0);
         end
         chk($sformatf("addr_t%0d", k), mem_addr, tap_addr(base, stride, k));
         chk($sformatf("idx_t%0d", k), idx, k);
         chk($sformatf("req_t%0d", k), mem_req, 1);
         chk($sformatf("valid_low_t%0d", k), res_valid, 0);
         mem_ack   = 1'b1;
         mem_rdata = mem_img[mem_addr];
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = '0;
      end
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, exp);
      chk("req_low_out", mem_req, 0);
      if (hold_n > 0) begin
         for (int h = 1; h < hold_n; h++) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, exp);
         end
         res_ready = 1'b1;
      end
      @(negedge clk);
      res_ready = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_valid", res_valid, 0);
      chk("idle_idx", idx, 1);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_in   = '0;
      ancho     = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      res_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", idx, 1);
      chk("rst_err", err, 0);
      rst = 1'b0;

      fill(100);
      run_window(0, 64, 0, 0, 1'b0);

      fill(0);
      mem_img[200 + 30 + 1] = 8'd255;
      run_window(200, 30, 0, 0, 1'b0);

      fill(0);
      mem_img[500] = 8'd255;
      mem_img[502] = 8'd255;
      mem_img[520] = 8'd255;
      mem_img[522] = 8'd255;
      run_window(500, 10, 0, 0, 1'b0);

      fill(255);
      run_window(10, 20, 0, 0, 1'b0);

      fill_random();
      run_window(4095, 3, 0, 0, 1'b0);

      fill_random();
      run_window(100, 40, 3, 5, 1'b1);

      // Asynchronous reset while tap 5 is outstanding.
      fill(7);
      @(negedge clk);
      start   = 1'b1;
      base_in = ADDR_W'(300);
      ancho   = 8'd16;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_img[mem_addr];
         @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("pre_rst_idx", idx, 5);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_req", mem_req, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_valid", res_valid, 0);
      chk("async_rst_idx", idx, 1);
      chk("async_rst_addr", mem_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      fill(50);
      run_window(300, 16, 1, 0, 1'b0);

      // Narrow stride is rejected.
      @(negedge clk);
      start   = 1'b1;
      base_in = ADDR_W'(5);
      ancho   = 8'd2;
      @(negedge clk);
      start = 1'b0;
      chk("reject_err", err, 1);
      chk("reject_busy", busy, 0);
      chk("reject_req", mem_req, 0);
      @(negedge clk);
      chk("reject_err_drop", err, 0);
      chk("reject_req_after", mem_req, 0);
      chk("reject_busy_after", busy, 0);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_window($urandom_range(0, MEM_N - 1), $urandom_range(3, 255),
                    $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
